// File: rtl/fpu_mmio_ctrl.sv
// fpu_mmio_ctrl: bus front end that sequences one pipelined FPU operation.
//
// Register window (offsets from BASE_ADR, word select on DataAdr[12:2]):
//   0x00 A (RW)   0x04 B (RW)   0x08 CMD (WO, reads 0)
//   0x0C RESULT (RO)   0x10 STATUS (RO, W1C on [3:1])   0x14-0x1C reserved
// STATUS: [0] busy, [1] done, [2] err_busy, [3] err_timeout.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   MemWrite          bus write strobe
//   DataAdr           bus byte address
//   WriteData         bus write data
//   ReadData          window read data (0 outside the window), combinational
//   fpu_hit           DataAdr inside the 32-byte window
//   fpu_start         one-cycle issue pulse to the FPU
//   fpu_op/a/b        opcode and operands held for the FPU
//   fpu_result        FPU result
//   fpu_valid         single-cycle FPU result strobe
//   irq               mirrors STATUS.done

module fpu_mmio_ctrl #(
   parameter logic [12:0] BASE_ADR = 13'h0600,
   parameter int          TIMEOUT  = 16,
   parameter int          OP_W     = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemWrite,
   input  logic [12:0]     DataAdr,
   input  logic [31:0]     WriteData,
   output logic [31:0]     ReadData,
   output logic            fpu_hit,
   output logic            fpu_start,
   output logic [OP_W-1:0] fpu_op,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   input  logic [31:0]     fpu_result,
   input  logic            fpu_valid,
   output logic            irq
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t state;
   state_t state_n;

   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [31:0]      result_q;
   logic             done_q;
   logic             err_busy_q;
   logic             err_to_q;
   logic [CNT_W-1:0] cnt_q;

   // Word offset relative to the window base; the byte lane bits are
   // not part of the decode.
   logic [10:0] word_off;
   logic [2:0]  word_sel;
   logic        unused_lane;

   assign word_off    = DataAdr[12:2] - BASE_ADR[12:2];
   assign word_sel    = word_off[2:0];
   assign fpu_hit     = (word_off[10:3] == 8'd0);
   assign unused_lane = ^DataAdr[1:0];

   logic wr_a;
   logic wr_b;
   logic wr_cmd;
   logic wr_st;

   assign wr_a   = MemWrite && fpu_hit && (word_sel == 3'd0);
   assign wr_b   = MemWrite && fpu_hit && (word_sel == 3'd1);
   assign wr_cmd = MemWrite && fpu_hit && (word_sel == 3'd2);
   assign wr_st  = MemWrite && fpu_hit && (word_sel == 3'd4);

   logic cmd_go;
   logic cmd_rej;
   logic fin_ok;
   logic fin_to;

   // An opcode of zero is a no-op and never leaves IDLE.
   assign cmd_go  = wr_cmd && (state == S_IDLE) &&
                    (WriteData[OP_W-1:0] != '0);
   assign cmd_rej = wr_cmd && (state != S_IDLE);
   // A valid result beats the watchdog on the same edge.
   assign fin_ok  = (state == S_WAIT) && fpu_valid;
   assign fin_to  = (state == S_WAIT) && !fpu_valid &&
                    (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      fpu_start = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_go) begin
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            fpu_start = 1'b1;
            state_n   = S_WAIT;
         end
         S_WAIT: begin
            if (fin_ok || fin_to) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_op     <= '0;
         done_q     <= 1'b0;
         err_busy_q <= 1'b0;
         err_to_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (wr_a) begin
            a_q <= WriteData;
         end
         if (wr_b) begin
            b_q <= WriteData;
         end

         // Operands come from the registers as they were before this
         // edge, so an A/B write on the CMD edge is not seen.
         if (cmd_go) begin
            fpu_a  <= a_q;
            fpu_b  <= b_q;
            fpu_op <= WriteData[OP_W-1:0];
         end

         if (state == S_ISSUE) begin
            cnt_q <= '0;
         end else if (state == S_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (fin_ok) begin
            result_q <= fpu_result;
         end

         // Hardware set has priority over software clear.
         if (cmd_go) begin
            done_q <= 1'b0;
         end else if (fin_ok) begin
            done_q <= 1'b1;
         end else if (wr_st && WriteData[1]) begin
            done_q <= 1'b0;
         end

         if (cmd_rej) begin
            err_busy_q <= 1'b1;
         end else if (wr_st && WriteData[2]) begin
            err_busy_q <= 1'b0;
         end

         if (cmd_go) begin
            err_to_q <= 1'b0;
         end else if (fin_to) begin
            err_to_q <= 1'b1;
         end else if (wr_st && WriteData[3]) begin
            err_to_q <= 1'b0;
         end
      end
   end

   logic [31:0] status_w;

   assign status_w = {28'd0, err_to_q, err_busy_q, done_q,
                      (state != S_IDLE)};

   always_comb begin
      ReadData = '0;
      if (fpu_hit) begin
         case (word_sel)
            3'd0:    ReadData = a_q;
            3'd1:    ReadData = b_q;
            3'd3:    ReadData = result_q;
            3'd4:    ReadData = status_w;
            default: ReadData = '0;
         endcase
      end
   end

   assign irq = done_q;

endmodule
